// File: rtl/io_bus_router_if.sv
// ---------------------------------------------------------------------------
// io_bus_router_if.sv
//
// Bus interfaces used by io_bus_router.
//
//   io_cpu_if : CPU memory-stage side of the router.
//       m_req    master -> router   access request, held until m_ready
//       m_we     master -> router   1 = write, 0 = read
//       m_addr   master -> router   access address
//       m_wdata  master -> router   write data
//       m_be     master -> router   byte enables
//       m_ready  router -> master   router can accept a request
//       m_done   router -> master   one-cycle completion pulse
//       m_rdata  router -> master   read data, valid with m_done
//       m_err    router -> master   bus error, valid with m_done
//
//   io_dev_if : device side of the router, one channel per slave.
//       s_sel    router -> slaves   one-hot slave select
//       s_we     router -> slaves   registered write flag
//       s_addr   router -> slaves   registered address
//       s_wdata  router -> slaves   registered write data
//       s_be     router -> slaves   registered byte enables
//       s_ack    slaves -> router   per-slave acknowledge
//       s_rdata  slaves -> router   per-slave read data, slice i = slave i
//
// In both interfaces the 'master' modport is the side that starts the
// transfer (CPU for io_cpu_if, router for io_dev_if) and 'slave' is the
// side that answers it.
// ---------------------------------------------------------------------------

interface io_cpu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  m_req;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_be;
    logic                  m_ready;
    logic                  m_done;
    logic [DATA_W-1:0]     m_rdata;
    logic                  m_err;

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_ready, m_done, m_rdata, m_err
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_ready, m_done, m_rdata, m_err
    );
endinterface

interface io_dev_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_SLV  = 3
);
    logic [N_SLV-1:0]        s_sel;
    logic                    s_we;
    logic [ADDR_W-1:0]       s_addr;
    logic [DATA_W-1:0]       s_wdata;
    logic [DATA_W/8-1:0]     s_be;
    logic [N_SLV-1:0]        s_ack;
    logic [N_SLV*DATA_W-1:0] s_rdata;

    modport master (
        output s_sel, s_we, s_addr, s_wdata, s_be,
        input  s_ack, s_rdata
    );

    modport slave (
        input  s_sel, s_we, s_addr, s_wdata, s_be,
        output s_ack, s_rdata
    );
endinterface

// File: rtl/io_bus_router.sv
// ---------------------------------------------------------------------------
// io_bus_router.sv
//
// Routes CPU memory-stage accesses to one of N_SLV slave channels. Each
// access is decoded against per-slave base/mask windows (lowest matching
// index wins, DEFAULT_SLV catches misses unless it equals N_SLV), the
// request is registered, and a request/acknowledge handshake with wait
// states runs on the selected channel. A decode miss or a slave that does
// not acknowledge within TIMEOUT wait cycles ends the access with a bus
// error, and the faulting address is kept in err_addr for software.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   cpu       io_cpu_if.slave   CPU request/response bus
//   dev       io_dev_if.master  slave select / data / acknowledge bus
//   busy      out  access in flight (ACCESS or RESP)
//   err_addr  out  address of the most recent errored access
//
// The ADDR_W/DATA_W/N_SLV parameters must match those of the connected
// interface instances.
// ---------------------------------------------------------------------------

module io_bus_router #(
    parameter int                      ADDR_W      = 32,
    parameter int                      DATA_W      = 32,
    parameter int                      N_SLV       = 3,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE    = {32'h0000_0000, 32'hFFFF_F000, 32'hFFFF_F060},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK    = {32'h0000_0000, 32'hFFFF_F0E0, 32'hFFFF_F0E0},
    parameter int                      DEFAULT_SLV = 0,
    parameter int                      TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    io_cpu_if.slave           cpu,
    io_dev_if.master          dev,
    output logic              busy,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t              state_q;
    state_t              state_d;

    // m_ready is held low through reset and for the cycle in which reset is
    // released; it rises only after the first clock edge that sees rst_n=1.
    logic                ready_q;

    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [BE_W-1:0]     req_be;
    logic [IDX_W-1:0]    req_idx;

    logic [CNT_W-1:0]    wait_cnt;
    logic                resp_err;
    logic [DATA_W-1:0]   resp_rdata;
    logic [ADDR_W-1:0]   err_addr_q;

    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic [N_SLV-1:0]    sel_onehot;
    logic                sel_ack;
    logic [DATA_W-1:0]   ack_rdata;
    logic                accept;
    logic                timeout_hit;

    // Address decode of the live request. The loop walks from the highest
    // index down so that the last assignment, and therefore the winner, is
    // the lowest matching slave. The default slave only applies when no
    // window matched and DEFAULT_SLV names a real channel.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((cpu.m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
        if (!dec_hit && (DEFAULT_SLV < N_SLV)) begin
            dec_hit = 1'b1;
            dec_idx = IDX_W'(DEFAULT_SLV);
        end
    end

    // Per-channel view of the registered slave index: the one-hot select,
    // the acknowledge of the selected channel only (acks from any other
    // channel are ignored), and the read data slice that belongs to it.
    always_comb begin
        sel_onehot = '0;
        ack_rdata  = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (req_idx == IDX_W'(i)) begin
                sel_onehot[i] = 1'b1;
                ack_rdata     = dev.s_rdata[i*DATA_W +: DATA_W];
            end
        end
        sel_ack = |(dev.s_ack & sel_onehot);
    end

    // A request is taken only while m_ready is high. The timeout fires in
    // the ACCESS cycle whose counter equals TIMEOUT, i.e. after TIMEOUT
    // wait cycles; an ack seen in that same cycle still completes normally.
    assign accept      = (state_q == ST_IDLE) && ready_q && cpu.m_req;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT));

    // State register. Reset is asynchronous so an access in flight is
    // dropped at once, including the slave select derived from the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
        end
    end

    // Next-state logic. A miss skips ACCESS and goes straight to the error
    // response; RESP always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = dec_hit ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (sel_ack || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture, wait counter and response registers. The request is
    // copied once at acceptance so the slave-side buses stay stable for the
    // whole access even if the master changes its outputs. The response is
    // prepared on the edge that enters RESP, and err_addr is loaded with
    // the registered address on every errored entry to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_be     <= '0;
            req_idx    <= '0;
            wait_cnt   <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            err_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        req_we    <= cpu.m_we;
                        req_addr  <= cpu.m_addr;
                        req_wdata <= cpu.m_wdata;
                        req_be    <= cpu.m_be;
                        req_idx   <= dec_idx;
                        wait_cnt  <= '0;
                        if (!dec_hit) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            err_addr_q <= cpu.m_addr;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ack) begin
                        resp_err   <= 1'b0;
                        resp_rdata <= req_we ? '0 : ack_rdata;
                    end else if (timeout_hit) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        err_addr_q <= req_addr;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the registered state. Response fields are
    // forced to zero outside RESP so the master never sees stale data.
    always_comb begin
        cpu.m_ready = (state_q == ST_IDLE) && ready_q;
        cpu.m_done  = (state_q == ST_RESP);
        cpu.m_err   = (state_q == ST_RESP) && resp_err;
        cpu.m_rdata = (state_q == ST_RESP) ? resp_rdata : '0;
        busy        = (state_q != ST_IDLE);
        dev.s_sel   = (state_q == ST_ACCESS) ? sel_onehot : '0;
    end

    assign dev.s_we    = req_we;
    assign dev.s_addr  = req_addr;
    assign dev.s_wdata = req_wdata;
    assign dev.s_be    = req_be;
    assign err_addr    = err_addr_q;

endmodule
